video_timing_gen: RTL and testbench

//  Raster timing generator and pixel-fetch aligner. Feeds the TMDS serialiser stage; runs in the pixel clock domain.

---
 rtl/video_pkg.sv | 51 +++++
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_delay_line.sv | 28 ++
 rtl/video_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the raster timing generator: standard
// timing sets, rgb888 field widths and the colour-bar table.
package video_pkg;

  localparam int CNT_W    = 12;
  localparam int RGB_CH_W = 8;
  localparam int RGB_W    = 3 * RGB_CH_W;
  localparam int NUM_BARS = 8;

  typedef logic [RGB_W-1:0] rgb888_t;

  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic             hs_pol;
    logic             vs_pol;
  } timing_t;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam timing_t TIMING_640X480_60 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
    hs_pol:   1'b0,    vs_pol: 1'b0
  };

  // 1280x720@60, 74.25 MHz pixel clock, positive syncs
  localparam timing_t TIMING_1280X720_60 = '{
    h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
    v_active: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20,
    hs_pol:   1'b1,     vs_pol: 1'b1
  };

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [NUM_BARS-1:0][RGB_W-1:0] COLOUR_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel request / returned data bus and the aligned encoder-side outputs
// of the raster timing generator.
interface video_timing_gen_if;
  import video_pkg::*;

  // O_req is a valid with no ready: the source cannot stall and must present
  // the pixel for each (O_x, O_y) exactly LATENCY cycles after the request.
  logic                O_req;
  logic [CNT_W-1:0]    O_x;
  logic [CNT_W-1:0]    O_y;
  logic                O_frame_start;
  rgb888_t             I_pix_rgb;

  logic                O_rgb_vs;
  logic                O_rgb_hs;
  logic                O_rgb_de;
  logic [RGB_CH_W-1:0] O_rgb_r;
  logic [RGB_CH_W-1:0] O_rgb_g;
  logic [RGB_CH_W-1:0] O_rgb_b;

  modport master (
    output O_req, O_x, O_y, O_frame_start,
    input  I_pix_rgb,
    output O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b
  );

  modport slave (
    input  O_req, O_x, O_y, O_frame_start,
    output I_pix_rgb,
    input  O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b
  );

endinterface

// File: rtl/video_delay_line.sv
// WIDTH x DEPTH shift register with hold enable; async reset loads every
// stage with RESET_VAL.
module video_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel-fetch aligner. Define TEST_PATTERN_EN to
// add I_pattern_sel and the built-in eight-bar colour pattern.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = int'(TIMING_640X480_60.h_active),
  parameter int H_FP     = int'(TIMING_640X480_60.h_fp),
  parameter int H_SYNC   = int'(TIMING_640X480_60.h_sync),
  parameter int H_BP     = int'(TIMING_640X480_60.h_bp),
  parameter int V_ACTIVE = int'(TIMING_640X480_60.v_active),
  parameter int V_FP     = int'(TIMING_640X480_60.v_fp),
  parameter int V_SYNC   = int'(TIMING_640X480_60.v_sync),
  parameter int V_BP     = int'(TIMING_640X480_60.v_bp),
  parameter bit HS_POL   = TIMING_640X480_60.hs_pol,
  parameter bit VS_POL   = TIMING_640X480_60.vs_pol,
  parameter int LATENCY  = 2
) (
  input  logic               I_pix_clk,
  input  logic               I_rst_n,
  input  logic               I_enable,
`ifdef TEST_PATTERN_EN
  input  logic               I_pattern_sel,
`endif
  video_timing_gen_if.master vid
);

  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 0
  logic             req_q;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             fs_q;
  logic             hs_raw_q;
  logic             vs_raw_q;

  // v only moves on the h wrap, so vs_raw_q can only change alongside h == 0
  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      req_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
      hs_raw_q <= 1'b0;
      vs_raw_q <= 1'b0;
    end else if (I_enable) begin
      h_q      <= h_d;
      v_q      <= v_d;
      req_q    <= (h_q < H_ACT) && (v_q < V_ACT);
      x_q      <= h_q;
      y_q      <= v_q;
      fs_q     <= (h_q == '0) && (v_q == '0);
      hs_raw_q <= in_window(h_q, H_SYNC_BEG, H_SYNC_END);
      vs_raw_q <= in_window(v_q, V_SYNC_BEG, V_SYNC_END);
    end
  end

  // ---------------------------------------------------------------- delay line
  logic dl_req;
  logic dl_hs;
  logic dl_vs;

`ifdef TEST_PATTERN_EN
  localparam int PIPE_W = 3 + CNT_W;
  logic [CNT_W-1:0]  dl_x;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  assign pipe_in                         = {req_q, hs_raw_q, vs_raw_q, x_q};
  assign {dl_req, dl_hs, dl_vs, dl_x}    = pipe_out;
`else
  localparam int PIPE_W = 3;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  assign pipe_in                         = {req_q, hs_raw_q, vs_raw_q};
  assign {dl_req, dl_hs, dl_vs}          = pipe_out;
`endif

  video_delay_line #(
    .WIDTH     (PIPE_W),
    .DEPTH     (LATENCY),
    .RESET_VAL ('0)
  ) u_ctrl_dly (
    .clk_i  (I_pix_clk),
    .rst_ni (I_rst_n),
    .en_i   (I_enable),
    .d_i    (pipe_in),
    .q_o    (pipe_out)
  );

  // ---------------------------------------------------------------- pixel select
  rgb888_t pix_sel;

`ifdef TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / NUM_BARS);
  logic [2:0] bar_idx;

  // Threshold compare against each bar edge avoids a divider on the column
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (dl_x >= CNT_W'(k) * BAR_W) bar_idx = 3'(k);
    end
  end

  always_comb begin
    pix_sel = vid.I_pix_rgb;
    if (I_pattern_sel) pix_sel = COLOUR_BARS[bar_idx];
  end
`else
  always_comb begin
    pix_sel = vid.I_pix_rgb;
  end
`endif

  // ---------------------------------------------------------------- output stage
  logic    de_q;
  logic    hs_q;
  logic    vs_q;
  rgb888_t rgb_q;

  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      rgb_q <= '0;
    end else if (I_enable) begin
      de_q  <= dl_req;
      hs_q  <= dl_hs ? HS_POL : ~HS_POL;
      vs_q  <= dl_vs ? VS_POL : ~VS_POL;
      rgb_q <= dl_req ? pix_sel : '0;
    end
  end

  assign vid.O_req         = req_q;
  assign vid.O_x           = x_q;
  assign vid.O_y           = y_q;
  assign vid.O_frame_start = fs_q;
  assign vid.O_rgb_de      = de_q;
  assign vid.O_rgb_hs      = hs_q;
  assign vid.O_rgb_vs      = vs_q;
  assign vid.O_rgb_r       = rgb_q[2*RGB_CH_W +: RGB_CH_W];
  assign vid.O_rgb_g       = rgb_q[RGB_CH_W   +: RGB_CH_W];
  assign vid.O_rgb_b       = rgb_q[0          +: RGB_CH_W];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced 24x8 raster with an echo pixel
// source; pattern checks are compiled in when TEST_PATTERN_EN is defined.
module tb_video_timing_gen;

  localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
  localparam int V_ACT = 4,  V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int H_TOT = 24, FRAME = 192;
  localparam int HS_BEG = 18, HS_END = 21, VS_BEG = 5, VS_END = 7;
  localparam int LAT = 3;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic pat_sel = 1'b0;

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  logic [7:0]  pop_x = '0;
  logic [23:0] exp_q[$];
  logic [23:0] src_q [LAT];

  video_timing_gen_if vif();

  video_timing_gen #(
    .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
    .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
    .HS_POL   (HS_POL), .VS_POL (VS_POL), .LATENCY (LAT)
  ) dut (
    .I_pix_clk     (clk),
    .I_rst_n       (rst_n),
    .I_enable      (en),
`ifdef TEST_PATTERN_EN
    .I_pattern_sel (pat_sel),
`endif
    .vid           (vif)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // Echo source: {x, y, 5A} for the request LAT cycles earlier
  always @(posedge clk) begin
    if (en) begin
      src_q[0] <= {vif.O_x[7:0], vif.O_y[7:0], 8'h5A};
      for (int i = 1; i < LAT; i++) src_q[i] <= src_q[i-1];
    end
  end
  assign vif.I_pix_rgb = src_q[LAT-1];

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_colour(input logic [7:0] x);
    case (x / 8'(H_ACT / 8))
      8'd0:    return 24'hFFFFFF;
      8'd1:    return 24'hFFFF00;
      8'd2:    return 24'h00FFFF;
      8'd3:    return 24'h00FF00;
      8'd4:    return 24'hFF00FF;
      8'd5:    return 24'hFF0000;
      8'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Positional model: pos counts enabled edges since reset release
  task automatic check_model();
    int p, h, v;
    logic [25:0] s0;
    logic e_de, e_hs, e_vs;
    s0 = '0;
    if (pos >= 1) begin
      p  = (pos - 1) % FRAME;
      h  = p % H_TOT;
      v  = p / H_TOT;
      s0 = {1'((h < H_ACT) && (v < V_ACT)), 12'(h), 12'(v), 1'(p == 0)};
    end
    check("stage0", 32'({vif.O_req, vif.O_x, vif.O_y, vif.O_frame_start}), 32'(s0));
    e_de = 1'b0;
    e_hs = ~HS_POL;
    e_vs = ~VS_POL;
    if (pos >= LAT + 2) begin
      p    = (pos - LAT - 2) % FRAME;
      h    = p % H_TOT;
      v    = p / H_TOT;
      e_de = (h < H_ACT) && (v < V_ACT);
      e_hs = (h >= HS_BEG && h < HS_END) ? HS_POL : ~HS_POL;
      e_vs = (v >= VS_BEG && v < VS_END) ? VS_POL : ~VS_POL;
    end
    check("ctrl_de_hs_vs", 32'({vif.O_rgb_de, vif.O_rgb_hs, vif.O_rgb_vs}), 32'({e_de, e_hs, e_vs}));
    if (!e_de) check("blank_rgb", 32'({vif.O_rgb_r, vif.O_rgb_g, vif.O_rgb_b}), 32'(0));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic tick();
    logic en_edge;
    logic [23:0] e;
    @(posedge clk);
    en_edge = en && rst_n;
    #1;
    if (en_edge) begin
      pos++;
      if (vif.O_rgb_de) begin
        check("sb_avail", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e     = exp_q.pop_front();
          pop_x = e[23:16];
          check("pixel", 32'({vif.O_rgb_r, vif.O_rgb_g, vif.O_rgb_b}),
                32'(pat_sel ? bar_colour(e[23:16]) : e));
        end
      end
      if (vif.O_req) exp_q.push_back({vif.O_x[7:0], vif.O_y[7:0], 8'h5A});
    end
    check_model();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int req_rise, de_rise, hs_fall, hs_cnt, vs_cnt, de_cnt, k;
    int fs_cyc[$];
    logic [23:0] first_pix;
    logic prev_hs, found;
    req_rise = -1; de_rise = -1; hs_fall = -1;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    first_pix = '0; prev_hs = 1'b1;

    repeat (3) tick();
    rst_n = 1'b1;
    en    = 1'b1;

    // Free run: frame period, latency, sync widths, first pixel
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      if (vif.O_frame_start) fs_cyc.push_back(cyc);
      if (req_rise < 0 && vif.O_req) req_rise = cyc;
      if (de_rise < 0 && vif.O_rgb_de) begin
        de_rise   = cyc;
        first_pix = {vif.O_rgb_r, vif.O_rgb_g, vif.O_rgb_b};
      end
      if (de_rise >= 0 && hs_fall < 0 && prev_hs && !vif.O_rgb_hs) hs_fall = cyc;
      prev_hs = vif.O_rgb_hs;
      if (cyc > 200 && cyc <= 200 + FRAME) begin
        hs_cnt += int'(vif.O_rgb_hs == 1'b0);
        vs_cnt += int'(vif.O_rgb_vs == 1'b1);
        de_cnt += int'(vif.O_rgb_de);
      end
    end
    check("fs_count", 32'(fs_cyc.size()), 32'(3));
    if (fs_cyc.size() >= 2) check("fs_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'(192));
    check("req_first", 32'(req_rise), 32'(1));
    check("de_latency", 32'(de_rise - req_rise), 32'(LAT + 1));
    check("first_pix", 32'(first_pix), 32'(24'h00005A));
    check("hs_fall_off", 32'(hs_fall - de_rise), 32'(18));
    check("hs_low_cnt", 32'(hs_cnt), 32'(24));
    check("vs_act_cnt", 32'(vs_cnt), 32'(48));
    check("de_cnt", 32'(de_cnt), 32'(64));

    // Freeze mid-line at x = 5
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      found = vif.O_req && (vif.O_x == 12'd5);
    end
    check("wait_x5", 32'(found), 32'(1));
    en = 1'b0;
    repeat (37) tick();
    check("frozen_x", 32'(vif.O_x), 32'(5));
    en = 1'b1;
    tick();
    check("resume_x", 32'(vif.O_x), 32'(6));

    // Reset mid-frame at (10,2)
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      found = vif.O_req && (vif.O_x == 12'd10) && (vif.O_y == 12'd2);
    end
    check("wait_x10y2", 32'(found), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    pos = 0;
    exp_q.delete();
    check_model();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_fs", 32'(vif.O_frame_start), 32'(1));
    k = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      k++;
      found = vif.O_rgb_de;
    end
    check("rst_de_lat", 32'(k), 32'(LAT + 1));

`ifdef TEST_PATTERN_EN
    pat_sel = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (vif.O_rgb_de && pop_x == 8'd1)
        check("bar_x1", 32'({vif.O_rgb_r, vif.O_rgb_g, vif.O_rgb_b}), 32'(24'hFFFFFF));
      if (vif.O_rgb_de && pop_x == 8'd2)
        check("bar_x2", 32'({vif.O_rgb_r, vif.O_rgb_g, vif.O_rgb_b}), 32'(24'hFFFF00));
      if (vif.O_rgb_de && pop_x == 8'd15)
        check("bar_x15", 32'({vif.O_rgb_r, vif.O_rgb_g, vif.O_rgb_b}), 32'(24'h000000));
    end
    pat_sel = 1'b0;
`endif

    repeat (30) tick();

    // ---------------------------------------------------------------- report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
